// File: rtl/burst_write_dma_if.sv
// rtl/burst_write_dma_if.sv - read-port and burst-write-port signal bundle for burst_write_dma
interface burst_write_dma_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
);
   logic                  io_in_rd;
   logic [ADDR_WIDTH-1:0] io_in_addr;
   logic [DATA_WIDTH-1:0] io_in_dout;
   logic                  io_in_wait_n;
   logic                  io_in_valid;
   logic                  io_out_wr;
   logic [ADDR_WIDTH-1:0] io_out_addr;
   logic [DATA_WIDTH-1:0] io_out_din;
   logic                  io_out_wait_n;
   logic                  io_out_burstDone;

   modport master (
      output io_in_rd, io_in_addr,
      input  io_in_dout, io_in_wait_n, io_in_valid,
      output io_out_wr, io_out_addr, io_out_din,
      input  io_out_wait_n, io_out_burstDone
   );

   modport slave (
      input  io_in_rd, io_in_addr,
      output io_in_dout, io_in_wait_n, io_in_valid,
      input  io_out_wr, io_out_addr, io_out_din,
      output io_out_wait_n, io_out_burstDone
   );
endinterface

// File: rtl/burst_write_dma.sv
// rtl/burst_write_dma.sv - word-read to burst-write block copier; BURST_WRITE_DMA_DONE_PULSE_EN adds io_done
module burst_write_dma #(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 32,
   parameter int BURST_LENGTH   = 16,
   parameter int TRANSFER_WORDS = 4194304,
   parameter int FIFO_DEPTH     = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic io_start,
   output logic io_busy,
`ifdef BURST_WRITE_DMA_DONE_PULSE_EN
   output logic io_done,
`endif
   burst_write_dma_if.master bus
);
   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int BYTE_SH  = $clog2(BYTES);
   localparam int BURST_SH = $clog2(BURST_LENGTH * BYTES);
   localparam int BURSTS   = TRANSFER_WORDS / BURST_LENGTH;
   localparam int WW       = (TRANSFER_WORDS > 1) ? $clog2(TRANSFER_WORDS) : 1;
   localparam int BW       = (BURSTS > 1) ? $clog2(BURSTS) : 1;
   localparam int OW       = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
   localparam int PW       = $clog2(FIFO_DEPTH);
   localparam int CW       = PW + 1;

   typedef enum logic [1:0] {IDLE, FILL, BURST, DONE} state_t;

   state_t                state, next_state;
   logic                  read_enable;
   logic [WW-1:0]         read_word;
   logic [BW-1:0]         burst;
   logic [OW-1:0]         out_word;
   logic [CW-1:0]         outstanding, fifo_count;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [CW:0]           in_flight;
   logic                  start, accept, push, pop, last_pop, done_step, last_burst;

   assign start      = io_start & ~io_busy;
   assign in_flight  = {1'b0, fifo_count} + {1'b0, outstanding};
   assign accept     = bus.io_in_rd & bus.io_in_wait_n;
   // Returned data with nothing in flight belongs to an aborted transfer.
   assign push       = bus.io_in_valid & (outstanding != '0);
   assign pop        = (state == BURST) & bus.io_out_wait_n;
   assign last_pop   = pop & (out_word == OW'(BURST_LENGTH - 1));
   assign done_step  = ((state == DONE) | last_pop) & bus.io_out_burstDone;
   assign last_burst = (burst == BW'(BURSTS - 1));

   assign io_busy         = read_enable | (state != IDLE);
   assign bus.io_in_rd    = read_enable & (in_flight < (CW + 1)'(FIFO_DEPTH));
   assign bus.io_in_addr  = ADDR_WIDTH'(read_word) << BYTE_SH;
   assign bus.io_out_addr = ADDR_WIDTH'(burst) << BURST_SH;
   assign bus.io_out_din  = fifo_mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= bus.io_in_dout;
   end

   always_ff @(posedge clock) begin
      if (reset || start) begin
         read_enable <= start;
         read_word   <= '0;
         burst       <= '0;
         out_word    <= '0;
         outstanding <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         if (accept) begin
            read_word <= read_word + 1'b1;
            if (read_word == WW'(TRANSFER_WORDS - 1)) read_enable <= 1'b0;
         end
         if (accept && !push)      outstanding <= outstanding + 1'b1;
         else if (!accept && push) outstanding <= outstanding - 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            out_word <= out_word + 1'b1;
         end
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (!push && pop) fifo_count <= fifo_count - 1'b1;
         if (done_step) burst <= burst + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state    = state;
      bus.io_out_wr = 1'b0;
      case (state)
         IDLE:  if (start) next_state = FILL;
         FILL:  if (fifo_count >= CW'(BURST_LENGTH)) next_state = BURST;
         BURST: begin
            bus.io_out_wr = 1'b1;
            // A commit coinciding with the final word skips the DONE cycle.
            if (last_pop) next_state = done_step ? (last_burst ? IDLE : FILL) : DONE;
         end
         DONE:  if (bus.io_out_burstDone) next_state = last_burst ? IDLE : FILL;
         default: next_state = IDLE;
      endcase
   end

`ifdef BURST_WRITE_DMA_DONE_PULSE_EN
   always_ff @(posedge clock) begin
      if (reset) io_done <= 1'b0;
      else       io_done <= done_step & last_burst;
   end
`endif
endmodule
